// File: rtl/uart_tx_if.sv
// Handshake bundle between a UART transmitter and its client.
// The client (master) supplies the baud tick, request and byte; the
// transmitter (slave) returns the serial line and frame status.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output baud_tick,
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  baud_tick,
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits. Every bit edge is aligned to baud_tick.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// SYNC   | byte latched, waiting for a tick so the start bit is full length
// START  | driving the start bit (0)
// DATA   | driving data bits, LSB first
// PARITY | driving the parity bit
// STOP   | driving stop bit(s) (1)
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  // Frame sequencer; the line only moves on tick edges outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (bus.tx_start) begin
            shift_reg <= bus.tx_data;
            parity_q  <= (^bus.tx_data) ^ (PARITY_ODD != 0);
            busy_q    <= 1'b1;
            state     <= SYNC;
          end
        end
        SYNC: begin
          if (bus.baud_tick) begin
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bus.baud_tick) begin
            tx_q      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bus.baud_tick) begin
            if (bit_idx != LAST_IDX) begin
              bit_idx   <= bit_idx + 1'b1;
              tx_q      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end else if (PARITY_EN != 0) begin
              tx_q  <= parity_q;
              state <= PARITY;
            end else begin
              tx_q     <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
        end
        PARITY: begin
          if (bus.baud_tick) begin
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bus.baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 7N2) share one
// stimulus stream and are each compared against a frame model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tick_cnt = 4'd0;
  logic       baud_tick;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Free-running baud generator: one tick every 16 clk.
  always @(posedge clk) tick_cnt <= tick_cnt + 4'd1;
  assign baud_tick = (tick_cnt == 4'd15);

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(7)) if3 ();

  assign if0.baud_tick = baud_tick; assign if0.tx_start = tx_start; assign if0.tx_data = tx_data;
  assign if1.baud_tick = baud_tick; assign if1.tx_start = tx_start; assign if1.tx_data = tx_data;
  assign if2.baud_tick = baud_tick; assign if2.tx_start = tx_start; assign if2.tx_data = tx_data;
  assign if3.baud_tick = baud_tick; assign if3.tx_start = tx_start; assign if3.tx_data = tx_data[6:0];

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .rst(rst), .bus(if3));

  logic [3:0] txv, busyv, donev;
  assign txv   = {if3.tx, if2.tx, if1.tx, if0.tx};
  assign busyv = {if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};
  assign donev = {if3.tx_done, if2.tx_done, if1.tx_done, if0.tx_done};

  function automatic int cfg_bits(input int d);
    return (d == 3) ? 7 : 8;
  endfunction
  function automatic bit cfg_par(input int d);
    return (d == 1) || (d == 2);
  endfunction
  function automatic bit cfg_odd(input int d);
    return d == 2;
  endfunction
  function automatic int cfg_stop(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  // Watch one DUT from its start bit to the cycle after tx_done.
  // lat = negedges waited until the start bit was first seen.
  task automatic check_frame(input int d, input logic [7:0] data, output int lat);
    bit e[16];
    int len = 0;
    int ones = 0;
    int bad;
    logic seen;
    e[len] = 1'b0; len++;
    for (int i = 0; i < cfg_bits(d); i++) begin
      e[len] = data[i]; len++;
      ones += int'(data[i]);
    end
    if (cfg_par(d)) begin
      e[len] = ((ones % 2) == 1) ^ cfg_odd(d); len++;
    end
    for (int i = 0; i < cfg_stop(d); i++) begin
      e[len] = 1'b1; len++;
    end
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (txv[d] === 1'b0) break;
    end
    n_cmp++;
    if (txv[d] !== 1'b0) begin
      n_err++;
      $display("FAIL start_bit dut%0d: tx=%b after %0d cycles, required 0 within 40", d, txv[d], lat);
      return;
    end
    for (int b = 0; b < len; b++) begin
      bad = 0;
      seen = e[b];
      for (int s = 0; s < 16; s++) begin
        if (b > 0 || s > 0) @(negedge clk);
        if (txv[d] !== e[b] || busyv[d] !== 1'b1) begin
          bad++;
          seen = txv[d];
        end
      end
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL frame_bit dut%0d bit%0d data=%h: saw tx=%b in %0d of 16 cycles (busy=%b), required tx=%b busy=1 for 16 cycles",
                 d, b, data, seen, bad, busyv[d], e[b]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (donev[d] !== 1'b1 || busyv[d] !== 1'b0) begin
      n_err++;
      $display("FAIL done_edge dut%0d: done=%b busy=%b, required done=1 busy=0", d, donev[d], busyv[d]);
    end
    @(negedge clk);
    n_cmp++;
    if (donev[d] !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse dut%0d: done=%b one cycle later, required 0", d, donev[d]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busyv !== 4'h0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busyv !== 4'h0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b after 400 cycles, required 0000", busyv);
    end
  endtask

  // Request a frame; busy must rise exactly one cycle after acceptance.
  task automatic send(input logic [7:0] d, input bit hold);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    n_cmp++;
    if (busyv !== 4'h0) begin
      n_err++;
      $display("FAIL busy_before: busy=%b, required 0000", busyv);
    end
    @(negedge clk);
    n_cmp++;
    if (busyv !== 4'hF) begin
      n_err++;
      $display("FAIL busy_after: busy=%b, required 1111", busyv);
    end
    if (!hold) begin
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic check_lat(input int d, input int lat);
    n_cmp++;
    if (lat < 1 || lat > 16) begin
      n_err++;
      $display("FAIL sync_latency dut%0d: %0d cycles, required 1..16", d, lat);
    end
  endtask

  task automatic send_and_check(input logic [7:0] d);
    int lat[4];
    send(d, 1'b0);
    fork
      check_frame(0, d, lat[0]);
      check_frame(1, d, lat[1]);
      check_frame(2, d, lat[2]);
      check_frame(3, d, lat[3]);
    join
    for (int i = 0; i < 4; i++) check_lat(i, lat[i]);
    wait_idle();
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txv !== 4'hF || busyv !== 4'h0 || donev !== 4'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d of %0d cycles not idle (tx=%b busy=%b done=%b), required tx=1111 busy=0000 done=0000",
               name, bad, cycles, txv, busyv, donev);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (txv !== 4'hF || busyv !== 4'h0 || donev !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b, required 1111/0000/0000", txv, busyv, donev);
    end
    rst = 1'b0;
    send(8'hC3, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (txv !== 4'hF || busyv !== 4'h0 || donev !== 4'h0) begin
      n_err++;
      $display("FAIL reset_midframe: tx=%b busy=%b done=%b, required 1111/0000/0000", txv, busyv, donev);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet_window("reset_no_done", 60);
  endtask

  task automatic test_frames();
    send_and_check(8'hA5);
    send_and_check(8'h01);
    send_and_check(8'h7F);
    send_and_check(8'h00);
    send_and_check(8'hFF);
  endtask

  task automatic test_ignored_start();
    int lat[4];
    send(8'h5A, 1'b0);
    fork
      check_frame(0, 8'h5A, lat[0]);
      check_frame(1, 8'h5A, lat[1]);
      check_frame(2, 8'h5A, lat[2]);
      check_frame(3, 8'h5A, lat[3]);
      begin
        repeat (45) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    quiet_window("ignored_start_no_frame", 80);
  endtask

  task automatic test_back_to_back();
    int l0, l3, m0, m3;
    wait_idle();
    send(8'h55, 1'b1);
    tx_data = 8'hAA;
    fork
      check_frame(0, 8'h55, l0);
      check_frame(3, 8'h55, l3);
    join
    n_cmp++;
    if (busyv[0] !== 1'b1 || busyv[3] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy8n1=%b busy7n2=%b the cycle after done, required 1/1", busyv[0], busyv[3]);
    end
    tx_start = 1'b0;
    fork
      check_frame(0, 8'hAA, m0);
      check_frame(3, 8'hAA, m3);
    join
    n_cmp++;
    if (m0 != 15 || m3 != 15) begin
      n_err++;
      $display("FAIL b2b_gap: start after %0d/%0d cycles of steady high, required 15/15", m0, m3);
    end
    wait_idle();
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      d = 8'($urandom);
      send_and_check(d);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that sits directly downstream of the baud-rate tick generator.
- Accepts a parallel byte through a start/busy handshake and shifts it out LSB-first on a single line: start bit, DATA_BITS data bits, optional parity, then STOP_BITS stop bits.
- Every bit boundary is aligned to the incoming baud_tick pulse, so every bit lasts exactly one tick period.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk-wide pulse, once per bit period, from the baud generator.
- tx_start  input  1  request to send; sampled only while tx_busy=0.
- tx_data  input  DATA_BITS  byte to send; sampled only in the acceptance cycle.
- tx  output  1  serial line; idles high; registered.
- tx_busy  output  1  high from the cycle after acceptance until frame end; registered.
- tx_done  output  1  one-clk pulse marking the end of the last stop bit; registered.

Behaviour:
- Reset, synchronous and active-high: tx=1, tx_busy=0, tx_done=0, state=IDLE, bit index=0, stop count=0, shift register=0.
- Reset mid-frame: the line returns high on the next edge. A truncated frame on the wire is acceptable, and no tx_done is issued.
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - tx_start=1 is an acceptance: latch tx_data into the shift register, compute parity, go to SYNC, set tx_busy=1.
  - baud_tick is ignored in IDLE.
- SYNC:
  - tx=1 while waiting for the next baud_tick.
  - On that tick, go to START with tx<=0.
  - The start bit therefore begins on a tick edge and is never shortened.
  - Latency from acceptance to the start-bit edge is 1..(tick period) clk cycles.
- START: on baud_tick, go to DATA with tx<=data[0] and bit index=0.
- DATA, on baud_tick:
  - If bit index < DATA_BITS-1: increment the index and drive the next data bit (LSB first).
  - Otherwise: if PARITY_EN, go to PARITY with tx<=parity; else go to STOP with tx<=1 and stop count=0.
- PARITY:
  - Parity bit = XOR of the latched data bits, inverted when PARITY_ODD=1.
  - On baud_tick, go to STOP with tx<=1 and stop count=0.
- STOP, on baud_tick:
  - If stop count == STOP_BITS-1: go to IDLE, tx_busy<=0, tx_done<=1 for exactly one clk.
  - Otherwise increment the stop count; tx stays 1.
- Handshake:
  - tx_start while tx_busy=1 is ignored; no queuing.
  - tx_data changes after acceptance have no effect on the frame in flight.
- Back-to-back frames: with tx_start held high, the next frame is accepted on the first clk after tx_done, i.e. the cycle in which state=IDLE.
- Frame length: 1 + DATA_BITS + PARITY_EN + STOP_BITS tick periods, plus the SYNC wait.
- Outputs change only on clk edges. tx changes only on edges where baud_tick=1, apart from reset.

Test Plan:
- Reset: assert rst for 3 cycles mid-DATA of a frame -> the next cycle shows tx=1, tx_busy=0, tx_done=0; no tx_done pulse follows.
- 8N1 send of 0xA5, baud_tick every 16 clk -> tx shows 0,1,0,1,0,0,1,0,1,1:
  - each bit held exactly 16 clk;
  - tx_busy high from the cycle after acceptance;
  - one tx_done pulse coincident with tx_busy falling.
- Parity: PARITY_EN=1 with 0xA5 -> parity bit 0 for even, 1 for odd. With 0x01 -> even parity 1.
- Ignored start: pulse tx_start with 0x3C during the DATA bits of frame 0x5A -> the wire carries only 0x5A; no second frame, and tx_busy falls once.
- Back-to-back: hold tx_start=1 with 0x55, then 0xAA -> two complete frames, the second accepted the cycle after the first tx_done, with no glitch on tx between stop and SYNC.
- STOP_BITS=2, DATA_BITS=7 with 0x7F -> start, seven 1s, two stop bits of 16 clk each (32 clk high) before tx_done.
